stream_mux_arb: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, a registered output stage, and packet-atomic arbitration. It replaces the fixed 2:1 32-bit combinational mux wherever several producers share one consumer, for example writeback sources or memory-request ports. The channel is picked by an external select or by an internal round-robin arbiter. A grant, once issued, is held until the end of the packet.

---
 rtl/stream_mux_arb.sv | 172 +++++++++++++++++
 tb/tb_stream_mux_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream multiplexer with a registered
// output stage and packet-atomic arbitration. The channel comes from an
// external select (MODE=0) or from a round-robin search (MODE=1). Once a
// multi-beat packet starts, its grant is held until the last beat is taken.
module stream_mux_arb #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  CHANNELS = 4,
  parameter int unsigned  MODE     = 0,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_last,
  output logic [CHANNELS-1:0]         in_ready,
  input  logic [SELW-1:0]             select,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic [SELW-1:0]             out_channel,
  input  logic                        out_ready
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SELW-1:0]   out_channel_q, out_channel_d;

  logic [SELW-1:0]   rr_cand;
  logic [SELW-1:0]   rr_gnt;
  logic              rr_vld;
  logic [SELW-1:0]   gnt;
  logic              gnt_vld;
  logic              sel_valid;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;
  logic              space;
  logic              accept;
  logic [SELW-1:0]   rr_next;

  // Round-robin search: first valid channel at or above rr_ptr, wrapping.
  always_comb begin
    rr_cand = '0;
    rr_gnt  = '0;
    rr_vld  = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      rr_cand = SELW'((32'(rr_ptr_q) + k) % CHANNELS);
      if (!rr_vld && in_valid[rr_cand]) begin
        rr_gnt = rr_cand;
        rr_vld = 1'b1;
      end
    end
  end

  // Grant selection: locked channel wins; otherwise select or round-robin.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (state_q == LOCK) begin
      gnt     = lock_ch_q;
      gnt_vld = 1'b1;
    end else if (MODE == 0) begin
      gnt     = select;
      // Out-of-range select (non-power-of-two CHANNELS) yields no grant.
      gnt_vld = (32'(select) < CHANNELS);
    end else begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end
  end

  // Multiplex the granted channel's beat; other channels never reach output.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (gnt == SELW'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: ready goes only to the granted channel, independent of its valid.
  always_comb begin
    space    = !out_valid_q || out_ready;
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = gnt_vld && space && (gnt == SELW'(i));
    end
    accept   = gnt_vld && space && sel_valid;
    rr_next  = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + SELW'(1);
  end

  // Next-state logic for the packet lock FSM and the round-robin pointer.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (accept && !sel_last) begin
          state_d   = LOCK;
          lock_ch_d = gnt;
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (accept && sel_last) begin
      rr_ptr_d = rr_next;
    end
  end

  // Output register: load on accept, drain when consumer takes the beat.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_channel_d = out_channel_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data;
      out_last_d    = sel_last;
      out_channel_d = gnt;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      lock_ch_q     <= '0;
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      lock_ch_q     <= lock_ch_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: a 2-channel select-mode instance driven from a
// vector table, plus 4-channel select-mode and round-robin instances fed by
// per-channel source queues and checked against an expected-beat scoreboard.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 2-channel select-mode instance (table vectors)
  logic [1:0]  s2_vld, s2_last, s2_rdy;
  logic [63:0] s2_data;
  logic        s2_sel, s2_ov, s2_ol, s2_och, s2_ordy;
  logic [31:0] s2_od;

  stream_mux_arb #(.WIDTH(32), .CHANNELS(2), .MODE(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2_vld), .in_data(s2_data),
    .in_last(s2_last), .in_ready(s2_rdy), .select(s2_sel),
    .out_valid(s2_ov), .out_data(s2_od), .out_last(s2_ol),
    .out_channel(s2_och), .out_ready(s2_ordy));

  // ---------------- 4-channel instances: index 0 = select mode, 1 = round-robin
  logic [3:0]   vld [2];
  logic [3:0]   last [2];
  logic [3:0]   rdy [2];
  logic [127:0] data [2];
  logic [1:0]   sel [2];
  logic         ov [2];
  logic         ol [2];
  logic [31:0]  od [2];
  logic [1:0]   och [2];
  logic         ordy [2];

  stream_mux_arb #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_data(data[0]),
    .in_last(last[0]), .in_ready(rdy[0]), .select(sel[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_channel(och[0]), .out_ready(ordy[0]));

  stream_mux_arb #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_data(data[1]),
    .in_last(last[1]), .in_ready(rdy[1]), .select(sel[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_channel(och[1]), .out_ready(ordy[1]));

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  ch;
  } beat_t;

  beat_t      srcq [2][4][$];
  beat_t      expq [2][$];
  int         xlog [2][$];
  bit         gate [2];
  logic [3:0] acc [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int ch, input logic [31:0] dat, input logic lst);
    beat_t b;
    b.data = dat; b.last = lst; b.ch = 2'(ch);
    srcq[d][ch].push_back(b);
  endtask

  task automatic expect_beat(input int d, input int ch, input logic [31:0] dat, input logic lst);
    beat_t b;
    b.data = dat; b.last = lst; b.ch = 2'(ch);
    expq[d].push_back(b);
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      for (int ch = 0; ch < 4; ch++) srcq[d][ch].delete();
    end
  endtask

  function automatic bit idle(input int d);
    bit r;
    r = (expq[d].size() == 0);
    for (int ch = 0; ch < 4; ch++) if (srcq[d][ch].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input int d, input string name);
    for (int i = 0; i < 60; i++) begin
      if (idle(d)) break;
      @(negedge clk);
    end
    checks++;
    if (!idle(d)) begin
      errors++;
      $display("FAIL %s drain timeout: %0d beats outstanding, required 0", name, expq[d].size());
      clear_all();
    end
    @(negedge clk);
  endtask

  // Source driver and output monitor for the 4-channel instances. Inputs
  // change 1 time unit after the falling edge; handshakes are sampled 1 unit
  // before the rising edge that completes them.
  initial begin
    acc[0] = '0; acc[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 4; ch++)
          if (acc[d][ch] && srcq[d][ch].size() > 0) void'(srcq[d][ch].pop_front());
      #1;
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 4; ch++) begin
          if (!gate[d] && srcq[d][ch].size() > 0) begin
            vld[d][ch]          = 1'b1;
            last[d][ch]         = srcq[d][ch][0].last;
            data[d][ch*32 +: 32] = srcq[d][ch][0].data;
          end else begin
            vld[d][ch]          = 1'b0;
            last[d][ch]         = 1'b0;
            data[d][ch*32 +: 32] = '0;
          end
        end
      #3;
      for (int d = 0; d < 2; d++) begin
        acc[d] = rst_n ? (vld[d] & rdy[d]) : 4'b0000;
        if (rst_n && ov[d] && ordy[d]) begin
          xlog[d].push_back(cyc);
          if (expq[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut%0d: got data %h ch %0d, required no beat", d, od[d], och[d]);
          end else begin
            beat_t e;
            e = expq[d].pop_front();
            chk($sformatf("beat dut%0d {data,last,ch}", d), {od[d], ol[d], och[d]}, {e.data, e.last, e.ch});
          end
        end
      end
    end
  end

  // Table vectors for the 2-channel instance (single-beat packets only).
  typedef struct {
    logic        sel;
    logic [1:0]  v;
    logic [31:0] d0, d1;
    logic        ordy;
    logic [1:0]  erdy;
    logic        eov;
    logic [31:0] eod;
    logic        ech;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 2'b11, 32'h12345678, 32'h87654321, 1'b1, 2'b01, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 32'h12345678, 32'h543210FF, 1'b1, 2'b10, 1'b1, 32'h543210FF, 1'b1};
    vecs[2] = '{1'b0, 2'b10, 32'h00000000, 32'h11111111, 1'b1, 2'b01, 1'b0, 32'h543210FF, 1'b1};
    vecs[3] = '{1'b1, 2'b10, 32'h00000000, 32'hDEADBEEF, 1'b1, 2'b10, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{1'b0, 2'b01, 32'hCAFEF00D, 32'h00000000, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{1'b0, 2'b01, 32'hCAFEF00D, 32'h00000000, 1'b1, 2'b01, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b0, 2'b00, 32'h00000000, 32'h00000000, 1'b1, 2'b01, 1'b0, 32'hCAFEF00D, 1'b0};

    rst_n = 1'b0;
    s2_vld = '0; s2_last = 2'b11; s2_data = '0; s2_sel = 1'b0; s2_ordy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      gate[d] = 1'b0; sel[d] = 2'd0; ordy[d] = 1'b1;
      vld[d] = '0; last[d] = '0; data[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---- 2-channel table
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      s2_sel  = vecs[i].sel;
      s2_vld  = vecs[i].v;
      s2_data = {vecs[i].d1, vecs[i].d0};
      s2_ordy = vecs[i].ordy;
      #3;
      chk($sformatf("vec%0d in_ready", i), 64'(s2_rdy), 64'(vecs[i].erdy));
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 64'(s2_ov), 64'(vecs[i].eov));
      chk($sformatf("vec%0d out_data", i), 64'(s2_od), 64'(vecs[i].eod));
      chk($sformatf("vec%0d out_channel", i), 64'(s2_och), 64'(vecs[i].ech));
    end
    s2_vld = '0;

    // ---- asynchronous reset with a beat held in both output registers
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    push(0, 0, 32'hA0A0A0A0, 1'b1);
    push(1, 0, 32'hB0B0B0B0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset out_valid sel", 64'(ov[0]), 64'd1);
    chk("pre_reset out_valid rr", 64'(ov[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset dut%0d {valid,data,last,ch}", d),
          {od[d], ov[d], ol[d], och[d]}, 64'd0);
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    #3;
    chk("post_reset in_ready rr", 64'(rdy[1]), 64'h0);
    chk("post_reset in_ready sel", 64'(rdy[0]), 64'h1);
    @(negedge clk);

    // ---- round-robin: all valid, single beats -> 0,1,2,3,0 back to back
    gate[1] = 1'b1;
    push(1, 0, 32'h10000000, 1'b1); push(1, 0, 32'h10000004, 1'b1);
    push(1, 1, 32'h10000001, 1'b1); push(1, 2, 32'h10000002, 1'b1);
    push(1, 3, 32'h10000003, 1'b1);
    expect_beat(1, 0, 32'h10000000, 1'b1); expect_beat(1, 1, 32'h10000001, 1'b1);
    expect_beat(1, 2, 32'h10000002, 1'b1); expect_beat(1, 3, 32'h10000003, 1'b1);
    expect_beat(1, 0, 32'h10000004, 1'b1);
    xlog[1].delete();
    @(negedge clk);
    gate[1] = 1'b0;
    wait_drain(1, "rr_all_valid");
    chk("rr_all_valid beat count", 64'(xlog[1].size()), 64'd5);
    if (xlog[1].size() == 5)
      chk("rr_all_valid cycle span", 64'(xlog[1][4] - xlog[1][0]), 64'd4);

    // ---- only ch2 valid: granted every cycle
    for (int i = 0; i < 3; i++) begin
      push(1, 2, 32'h20000000 + 32'(i), 1'b1);
      expect_beat(1, 2, 32'h20000000 + 32'(i), 1'b1);
    end
    wait_drain(1, "rr_only_ch2");

    // ---- wrap: rr_ptr=3, ch0 and ch3 valid -> ch3 then ch0
    gate[1] = 1'b1;
    push(1, 0, 32'h30000000, 1'b1); push(1, 3, 32'h30000003, 1'b1);
    expect_beat(1, 3, 32'h30000003, 1'b1); expect_beat(1, 0, 32'h30000000, 1'b1);
    @(negedge clk);
    gate[1] = 1'b0;
    wait_drain(1, "rr_wrap");

    // ---- packet lock: ch1 3-beat packet stalls mid-packet while ch0 waits
    gate[1] = 1'b1;
    push(1, 1, 32'hA1A1A1A1, 1'b0);
    push(1, 0, 32'hC0C0C0C0, 1'b1);
    expect_beat(1, 1, 32'hA1A1A1A1, 1'b0); expect_beat(1, 1, 32'hA2A2A2A2, 1'b0);
    expect_beat(1, 1, 32'hA3A3A3A3, 1'b1); expect_beat(1, 0, 32'hC0C0C0C0, 1'b1);
    @(negedge clk);
    gate[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 chk("rr_lock in_ready during stall", 64'(rdy[1]), 64'h2);
    @(negedge clk);
    push(1, 1, 32'hA2A2A2A2, 1'b0);
    push(1, 1, 32'hA3A3A3A3, 1'b1);
    wait_drain(1, "rr_lock");

    // ---- back-pressure: out_ready low 3 cycles, then drain in order
    ordy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1, 2, 32'hD0000000 + 32'(i), 1'b1);
      expect_beat(1, 2, 32'hD0000000 + 32'(i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk($sformatf("bp%0d out_valid", i), 64'(ov[1]), 64'd1);
      chk($sformatf("bp%0d out_data", i), 64'(od[1]), 64'hD0000000);
      chk($sformatf("bp%0d in_ready", i), 64'(rdy[1]), 64'h0);
    end
    @(negedge clk);
    ordy[1] = 1'b1;
    wait_drain(1, "rr_backpressure");

    // ---- select mode: toggling select mid-packet keeps the packet whole
    gate[0] = 1'b1;
    sel[0] = 2'd1;
    push(0, 1, 32'hE1E1E1E1, 1'b0); push(0, 1, 32'hE2E2E2E2, 1'b0);
    push(0, 1, 32'hE3E3E3E3, 1'b1);
    push(0, 0, 32'hF0F0F0F0, 1'b1); push(0, 2, 32'hF2F2F2F2, 1'b1);
    expect_beat(0, 1, 32'hE1E1E1E1, 1'b0); expect_beat(0, 1, 32'hE2E2E2E2, 1'b0);
    expect_beat(0, 1, 32'hE3E3E3E3, 1'b1); expect_beat(0, 2, 32'hF2F2F2F2, 1'b1);
    expect_beat(0, 0, 32'hF0F0F0F0, 1'b1);
    @(negedge clk);
    gate[0] = 1'b0;
    @(negedge clk);
    sel[0] = 2'd0;
    @(negedge clk);
    sel[0] = 2'd2;
    @(negedge clk);
    @(negedge clk);
    sel[0] = 2'd0;
    wait_drain(0, "sel_lock");

    // ---- select mode: selected channel invalid, no fallback to ch0
    sel[0] = 2'd2;
    push(0, 0, 32'h0B0B0B0B, 1'b1);
    expect_beat(0, 0, 32'h0B0B0B0B, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      chk($sformatf("nofallback%0d out_valid", i), 64'(ov[0]), 64'd0);
      chk($sformatf("nofallback%0d in_ready", i), 64'(rdy[0]), 64'h4);
    end
    @(negedge clk);
    sel[0] = 2'd0;
    wait_drain(0, "sel_nofallback");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
